imem_loader: RTL
================

# imem_loader

Boot-time loader that fills the instruction memory from a byte stream before the single-cycle MIPS core runs. It accepts bytes over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory's synchronous write port. It holds the CPU in reset (`cpu_hold`) until the programmed word count has been written, replacing the simulation-only `$readmemh` preload path.

## Interface

**Parameters**
- `ADDR_W`, default 6: word-address width of the instruction memory.
- `DEPTH`, default 64: number of words; must equal 2^ADDR_W.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader can accept a byte.
- `we` out 1: instruction-memory write enable, one-cycle pulse.
- `waddr` out ADDR_W: instruction-memory word address.
- `wdata` out 32: instruction word.
- `done` out 1: load complete, sticky until reset.
- `err` out 1: checksum mismatch, sticky until reset. Constant 0 when the checksum feature is compiled out.
- `cpu_hold` out 1: hold-CPU-in-reset; equals `~done`.

## Operation

- A byte is accepted on a posedge where `in_valid && in_ready`. Bytes are never dropped or duplicated.
- **States:** IDLE, HDR, LOAD, CHK (only when the checksum feature is compiled in), DONE, ERR.
- **IDLE:** entered on reset. Unconditional move to HDR on the next cycle.
- **HDR:** accept one header byte. Word count N = `hdr[ADDR_W-1:0] + 1`, range 1..DEPTH. Upper header bits are ignored. Clear the word index, byte index and checksum. Go to LOAD.
- **LOAD:**
  - Accept bytes MSB-first: byte0 → `wdata[31:24]`, up to byte3 → `[7:0]`.
  - The 2-bit byte index wraps 3→0.
  - After byte3 is accepted, pulse `we` with `waddr` = word index, then increment the word index.
  - After word N-1 is accepted, go to CHK if the feature is compiled in, otherwise DONE.
- **CHK:** accept one byte and compare it against the running XOR of all data bytes (the header is excluded). Match → DONE. Mismatch → ERR.
- **DONE:** `done`=1, `in_ready`=0. Stays here until reset.
- **ERR:** `err`=1, `done`=0, `in_ready`=0. Stays here until reset.
- `in_ready` = 1 exactly in HDR, LOAD and CHK. It is decoded from the state register and does not depend on `in_valid`.
- Word-index arithmetic is ADDR_W+1 bits, so N=DEPTH terminates without aliasing. `waddr` never exceeds DEPTH-1.

## Timing

- **Reset values:** `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `done`=0, `err`=0, `cpu_hold`=1. State = IDLE, all counters 0.
- `in_ready` first rises 1 cycle after `reset` deasserts (IDLE→HDR).
- **Write latency:**
  - `we`, `waddr` and `wdata` are registered.
  - `we` is high in the cycle after byte3 of a word is accepted, for exactly 1 cycle.
  - `waddr` and `wdata` are stable in that cycle and hold their values afterwards.
- **Completion latency:**
  - Without the checksum feature, `done` rises in the same cycle as the final `we` pulse, so memory is written on that edge. `cpu_hold` falls in that same cycle.
  - With the checksum feature, `done` or `err` rises the cycle after the checksum byte is accepted.
- **Back-to-back bytes:** with continuous `in_valid`, a word is written every 4 cycles. Gaps in `in_valid` only stall; no timeout.
- **Reset mid-load:** all outputs return to reset values on that edge and a pending `we` is suppressed. Words already written remain in memory; the next stream restarts from the header.
- `in_valid` while `in_ready`=0 has no effect.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHK state present; one trailing XOR checksum byte is required after the data.
  - `err` is driven as described in Operation.
- Not defined:
  - No CHK state; no checksum byte is consumed.
  - DONE is reached directly after the last word is written.
  - `err` is tied to 0.

## Test plan

- **Basic 2-word load** (macro off): after reset, stream 0x01, 0x20,0x08,0x00,0x05, 0xAC,0x09,0x00,0x04 → `we` at `waddr`=0 with `wdata`=0x20080005, then `waddr`=1 with 0xAC090004. `done`=1 and `cpu_hold`=0 in the same cycle as the second `we`. `in_ready`=0 afterwards.
- **Checksum good/bad** (macro on): same stream plus 0x8C → `done`=1, `err`=0. Repeat with 0x8D → `err`=1, `done`=0, `cpu_hold`=1, both words still written.
- **Full depth and header masking:** header 0xFF, then 256 bytes with word k = {k,k,k,k} → 64 writes, last at `waddr`=63 with 0x3F3F3F3F. `done` follows; no 65th write.
- **Backpressure/gaps:** same stream as the 2-word load, with `in_valid` randomly low 50% of cycles → identical writes and data; each `we` is 1 cycle wide.
- **Reset mid-load:** assert `reset` one cycle after byte2 of word 1 is accepted → no `we` for word 1, all outputs at reset values. Reloading the 2-word stream then succeeds.
- **Ignored input:** hold `in_valid`=1 during IDLE and DONE → no byte consumed, no `we`.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time loader for the single-cycle MIPS instruction memory. It takes a
// byte stream over a valid/ready handshake, assembles big-endian 32-bit words
// and drives the instruction memory's synchronous write port. The CPU is held
// in reset (cpu_hold) until the programmed number of words has been written.
//
// Stream format:  header byte, then N*4 data bytes (MSB first per word),
//                 then one XOR checksum byte when the checksum is enabled.
//                 N = header[ADDR_W-1:0] + 1; upper header bits are ignored.
//
// Compile-time option:
//   IMEM_LOADER_CHECKSUM_EN  - when defined, a trailing XOR checksum byte over
//                              all data bytes is consumed and checked; err
//                              flags a mismatch. When undefined, the load ends
//                              right after the last word and err is tied to 0.
//
// Parameters:
//   ADDR_W    word-address width of the instruction memory (<= 8)
//   DEPTH     number of words, must equal 2**ADDR_W
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte this cycle (HDR, LOAD, CHK)
//   we        instruction-memory write enable, one-cycle pulse
//   waddr     instruction-memory word address
//   wdata     instruction word
//   done      load complete, sticky until reset
//   err       checksum mismatch, sticky until reset
//   cpu_hold  hold the CPU in reset, equals ~done
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;
`endif

  // Word counters are one bit wider than the address so that N = DEPTH is
  // representable and the final compare never aliases back to zero.
  localparam logic [ADDR_W:0] ONE       = 1;
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   word_next;
  logic [ADDR_W:0]   n_words;
  logic [1:0]        byte_idx;
  logic [23:0]       shift;
  logic              accept;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = in_valid && in_ready;
  assign word_next = word_idx + ONE;
  // The MAX_WORDS term is redundant for a well-formed header (n_words never
  // exceeds DEPTH) but guarantees waddr cannot run past DEPTH-1.
  assign last_word = (word_next == n_words) || (word_next == MAX_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_idx <= '0;
      n_words  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: state <= HDR;

        HDR: begin
          if (accept) begin
            n_words  <= {1'b0, in_data[ADDR_W-1:0]} + ONE;
            word_idx <= '0;
            byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (accept) begin
            // shift holds the three earlier bytes of the word, oldest on top.
            shift    <= {shift[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              we       <= 1'b1;
              waddr    <= word_idx[ADDR_W-1:0];
              wdata    <= {shift, in_data};
              word_idx <= word_next;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= DONE;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            state <= (in_data == csum) ? DONE : ERR;
          end
        end
`endif

        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are decoded straight from the state register, so they are
  // glitch-free and change only on the clock edge.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state == HDR) || (state == LOAD) || (state == CHK);
  assign err      = (state == ERR);
`else
  assign in_ready = (state == HDR) || (state == LOAD);
  assign err      = 1'b0;
`endif
  assign done     = (state == DONE);
  assign cpu_hold = ~done;

endmodule
